// File: rtl/vga_pixel_out_if.sv
// Pixel stream from the framebuffer reader into vga_pixel_out.
// Carries a 24-bit RGB beat with valid/ready handshake and a start-of-frame marker.
`timescale 1ns/1ps
interface vga_pixel_out_if;
   logic [23:0] pix_data;    // {R[23:16], G[15:8], B[7:0]}
   logic        pix_sop;     // beat is pixel (0,0) of a frame
   logic        pix_valid;
   logic        pix_ready;   // beat consumed this cycle

   modport master (output pix_data, output pix_sop, output pix_valid, input pix_ready);
   modport slave  (input pix_data, input pix_sop, input pix_valid, output pix_ready);
endinterface

// File: rtl/vga_pixel_out.sv
// vga_pixel_out: 640x480@60 VGA back end driven from a 50 MHz clock with a
// divide-by-2 pixel enable. Consumes an RGB pixel stream, flags underflow and
// frame misalignment, and resynchronises on the next start-of-frame beat.
// Optional colour-bar test pattern: define VGA_TEST_PATTERN_EN.
`timescale 1ns/1ps
module vga_pixel_out #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic                 clk,
   input  logic                 reset_n,
   vga_pixel_out_if.slave       pix,
`ifdef VGA_TEST_PATTERN_EN
   input  logic                 test_mode,
`endif
   input  logic                 err_clr,
   output logic                 underflow,
   output logic                 sync_err,
   output logic                 frame_start,
   output logic [7:0]           vga_r,
   output logic [7:0]           vga_g,
   output logic [7:0]           vga_b,
   output logic                 vga_clk,
   output logic                 vga_hs,
   output logic                 vga_vs,
   output logic                 vga_blank_n,
   output logic                 vga_sync_n
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic {
      SYNC_WAIT = 1'b0,
      RUN       = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic            pen_q;
   logic [HW-1:0]   hcnt_q;
   logic [VW-1:0]   vcnt_q;
   logic            active, at_origin, hs_d, vs_d;
   logic [23:0]     rgb_d;
   logic            set_uf, set_se;

   assign active     = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
   assign at_origin  = (hcnt_q == '0) && (vcnt_q == '0);
   assign hs_d       = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
   assign vs_d       = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
   assign vga_sync_n = 1'b0;

`ifdef VGA_TEST_PATTERN_EN
   localparam logic [HW-1:0] BAR_W = HW'(H_ACTIVE / 8);
   logic [2:0]  bar_idx;
   logic [23:0] bar_rgb;
   assign bar_idx = 3'(hcnt_q / BAR_W);
   assign bar_rgb = {{8{bar_idx[2]}}, {8{bar_idx[1]}}, {8{bar_idx[0]}}};
`endif

   // Pixel enable and raster counters; counters only move on slots.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pen_q  <= 1'b0;
         hcnt_q <= '0;
         vcnt_q <= '0;
      end else begin
         pen_q <= ~pen_q;
         if (pen_q) begin
            if (hcnt_q == H_LAST) begin
               hcnt_q <= '0;
               vcnt_q <= (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
            end else begin
               hcnt_q <= hcnt_q + 1'b1;
            end
         end
      end
   end

   // Stream state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= SYNC_WAIT;
      else          state_q <= state_d;
   end

   // Next state, ready, pixel selection and error detection.
   always_comb begin
      state_d       = state_q;
      pix.pix_ready = 1'b0;
      rgb_d         = '0;
      set_uf        = 1'b0;
      set_se        = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
      if (test_mode) begin
         // Stream is ignored; leaving test mode always resynchronises.
         state_d = SYNC_WAIT;
         if (active) rgb_d = bar_rgb;
      end else
`endif
      begin
         unique case (state_q)
            SYNC_WAIT: begin
               if (pix.pix_valid) begin
                  if (!pix.pix_sop) begin
                     pix.pix_ready = 1'b1;
                  end else if (pen_q && at_origin) begin
                     pix.pix_ready = 1'b1;
                     rgb_d         = pix.pix_data;
                     state_d       = RUN;
                  end
               end
            end
            RUN: begin
               if (pen_q && active) begin
                  if (!pix.pix_valid) begin
                     set_uf  = 1'b1;
                     state_d = SYNC_WAIT;
                  end else if (pix.pix_sop != at_origin) begin
                     // sop off-origin, or a non-sop beat at the origin
                     set_se  = 1'b1;
                     state_d = SYNC_WAIT;
                  end else begin
                     pix.pix_ready = 1'b1;
                     rgb_d         = pix.pix_data;
                  end
               end
            end
            default: state_d = SYNC_WAIT;
         endcase
      end
   end

   // VGA output registers; colour and sync update on slots only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         {vga_r, vga_g, vga_b} <= '0;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_blank_n <= 1'b0;
         vga_clk     <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         vga_clk     <= pen_q;
         frame_start <= pen_q && at_origin;
         if (pen_q) begin
            {vga_r, vga_g, vga_b} <= rgb_d;
            vga_hs      <= hs_d;
            vga_vs      <= vs_d;
            vga_blank_n <= active;
         end
      end
   end

   // Sticky error flags; a new error beats a simultaneous clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         underflow <= 1'b0;
         sync_err  <= 1'b0;
      end else begin
         underflow <= set_uf | (underflow & ~err_clr);
         sync_err  <= set_se | (sync_err & ~err_clr);
      end
   end

endmodule

// File: tb/tb_vga_pixel_out.sv
// Directed self-checking bench for vga_pixel_out. A reduced-timing instance
// (16x9 slot raster, 8x4 active) exercises the stream logic; a default-timing
// instance checks the real 640x480 horizontal timing.
`timescale 1ns/1ps
module tb_vga_pixel_out;

   localparam int HA = 8, HF = 2, HS = 3, HB = 3;
   localparam int VA = 4, VF = 1, VS = 2, VB = 2;
   localparam int HT = HA + HF + HS + HB;   // 16 slots per line

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic err_clr = 1'b0;
   always #5 clk = ~clk;

   vga_pixel_out_if sif ();
   vga_pixel_out_if fif ();

   logic       underflow, sync_err, frame_start, vclk, hs, vs, blank_n, sync_n;
   logic [7:0] r, g, b;
   logic [23:0] rgb;
   assign rgb = {r, g, b};

   logic       f_uf, f_se, f_fs, f_vclk, f_hs, f_vs, f_blank_n, f_sync_n;
   logic [7:0] f_r, f_g, f_b;

   vga_pixel_out #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
      .clk(clk), .reset_n(reset_n), .pix(sif),
`ifdef VGA_TEST_PATTERN_EN
      .test_mode(1'b0),
`endif
      .err_clr(err_clr), .underflow(underflow), .sync_err(sync_err),
      .frame_start(frame_start), .vga_r(r), .vga_g(g), .vga_b(b),
      .vga_clk(vclk), .vga_hs(hs), .vga_vs(vs), .vga_blank_n(blank_n),
      .vga_sync_n(sync_n)
   );

   vga_pixel_out full (
      .clk(clk), .reset_n(reset_n), .pix(fif),
`ifdef VGA_TEST_PATTERN_EN
      .test_mode(1'b0),
`endif
      .err_clr(1'b0), .underflow(f_uf), .sync_err(f_se),
      .frame_start(f_fs), .vga_r(f_r), .vga_g(f_g), .vga_b(f_b),
      .vga_clk(f_vclk), .vga_hs(f_hs), .vga_vs(f_vs), .vga_blank_n(f_blank_n),
      .vga_sync_n(f_sync_n)
   );

   int n_checks = 0;
   int n_fails  = 0;
   int edges    = 0;   // posedges since the last reset release

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      edges++;
   endtask

   task automatic at_edge(input int e);
      while (edges < e) tick();
   endtask

   // Park in the pen=1 cycle of slot s; inputs set now are taken at its edge.
   task automatic go_slot(input int s);
      at_edge(2 * s + 1);
   endtask

   // Feed pixel indices first..last-1 of the frame starting at slot org.
   task automatic feed_frame(input int org, input logic [23:0] off,
                             input int first, input int last);
      for (int i = first; i < last; i++) begin
         go_slot(org + (i / HA) * HT + (i % HA));
         sif.pix_valid = 1'b1;
         sif.pix_sop   = (i == 0);
         sif.pix_data  = off + 24'(i);
         #1 chk("ready_beat", 32'(sif.pix_ready), 32'd1);
         tick();
         chk("rgb_beat", 32'(rgb), 32'(off + 24'(i)));
         if (i == 0) chk("frame_start_beat", 32'(frame_start), 32'd1);
         sif.pix_valid = 1'b0;
         sif.pix_sop   = 1'b0;
      end
   endtask

   initial begin
      sif.pix_data = '0; sif.pix_sop = 1'b0; sif.pix_valid = 1'b0;
      fif.pix_data = '0; fif.pix_sop = 1'b0; fif.pix_valid = 1'b0;
      repeat (3) @(negedge clk);

      // reset values
      chk("rst_rgb", 32'(rgb), 32'd0);
      chk("rst_hs", 32'(hs), 32'd1);
      chk("rst_vs", 32'(vs), 32'd1);
      chk("rst_blank_n", 32'(blank_n), 32'd0);
      chk("rst_sync_n", 32'(sync_n), 32'd0);
      chk("rst_vga_clk", 32'(vclk), 32'd0);
      chk("rst_flags", {29'd0, underflow, sync_err, frame_start}, 32'd0);
      chk("rst_full_hs", 32'(f_hs), 32'd1);

      reset_n = 1'b1;
      edges   = 0;

      // free run, no stream
      at_edge(2);  chk("fs_first", 32'(frame_start), 32'd1);
                   chk("vga_clk_hi", 32'(vclk), 32'd1);
                   chk("full_fs_first", 32'(f_fs), 32'd1);
      at_edge(3);  chk("fs_pulse_end", 32'(frame_start), 32'd0);
                   chk("vga_clk_lo", 32'(vclk), 32'd0);
      at_edge(16); chk("blank_last_active", 32'(blank_n), 32'd1);
                   chk("rgb_sync_wait", 32'(rgb), 32'd0);
      at_edge(18); chk("blank_first_blank", 32'(blank_n), 32'd0);
      at_edge(20); chk("hs_before", 32'(hs), 32'd1);
      at_edge(22); chk("hs_first_low", 32'(hs), 32'd0);
      at_edge(26); chk("hs_last_low", 32'(hs), 32'd0);
      at_edge(28); chk("hs_after", 32'(hs), 32'd1);
      at_edge(160); chk("vs_before", 32'(vs), 32'd1);
      at_edge(162); chk("vs_first_low", 32'(vs), 32'd0);
      at_edge(224); chk("vs_last_low", 32'(vs), 32'd0);
      at_edge(226); chk("vs_after", 32'(vs), 32'd1);
      at_edge(288); chk("fs_period_early", 32'(frame_start), 32'd0);
      at_edge(290); chk("fs_period", 32'(frame_start), 32'd1);
      at_edge(1280); chk("full_blank_639", 32'(f_blank_n), 32'd1);
      at_edge(1282); chk("full_blank_640", 32'(f_blank_n), 32'd0);
      at_edge(1312); chk("full_hs_655", 32'(f_hs), 32'd1);
      at_edge(1314); chk("full_hs_656", 32'(f_hs), 32'd0);
      at_edge(1504); chk("full_hs_751", 32'(f_hs), 32'd0);
      at_edge(1506); chk("full_hs_752", 32'(f_hs), 32'd1);

      // sop mid-frame is held until the origin of frame at slot 864
      go_slot(757);
      sif.pix_valid = 1'b1; sif.pix_sop = 1'b1; sif.pix_data = 24'h000000;
      #1 chk("sop_held_a", 32'(sif.pix_ready), 32'd0);
      go_slot(800);
      #1 chk("sop_held_b", 32'(sif.pix_ready), 32'd0);
      feed_frame(864, 24'h000000, 0, HA * VA);
      chk("last_pixel", 32'(rgb), 32'h00001F);
      chk("no_uf", 32'(underflow), 32'd0);

      // underflow at pixel (3,1) of frame at 1008
      feed_frame(1008, 24'h000000, 0, 11);
      go_slot(1008 + HT + 3);
      sif.pix_valid = 1'b0;
      tick();
      chk("uf_rgb", 32'(rgb), 32'd0);
      chk("uf_flag", 32'(underflow), 32'd1);
      // non-sop beat afterwards is discarded
      go_slot(1008 + 2 * HT + 5);
      sif.pix_valid = 1'b1; sif.pix_sop = 1'b0; sif.pix_data = 24'hABCDEF;
      #1 chk("discard_ready", 32'(sif.pix_ready), 32'd1);
      tick();
      chk("discard_rgb", 32'(rgb), 32'd0);
      sif.pix_valid = 1'b0;

      // recovery on the next sop, flag stays sticky until cleared
      feed_frame(1152, 24'h100000, 0, HA * VA);
      chk("uf_sticky", 32'(underflow), 32'd1);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("uf_cleared", 32'(underflow), 32'd0);

      // sop on pixel (3,0) of frame at 1296
      feed_frame(1296, 24'h200000, 0, 3);
      go_slot(1299);
      sif.pix_valid = 1'b1; sif.pix_sop = 1'b1; sif.pix_data = 24'h5A5A5A;
      #1 chk("se_not_taken", 32'(sif.pix_ready), 32'd0);
      tick();
      chk("se_rgb", 32'(rgb), 32'd0);
      chk("se_flag", 32'(sync_err), 32'd1);
      chk("se_no_uf", 32'(underflow), 32'd0);
      go_slot(1350);
      #1 chk("se_held", 32'(sif.pix_ready), 32'd0);
      go_slot(1440);
      #1 chk("se_taken_origin", 32'(sif.pix_ready), 32'd1);
      tick();
      chk("se_resync_rgb", 32'(rgb), 32'h5A5A5A);
      chk("se_resync_fs", 32'(frame_start), 32'd1);
      sif.pix_valid = 1'b0; sif.pix_sop = 1'b0;
      feed_frame(1440, 24'h300000, 1, HA * VA);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("se_cleared", 32'(sync_err), 32'd0);

      // non-sop beat at origin in RUN, with a simultaneous clear
      go_slot(1584);
      sif.pix_valid = 1'b1; sif.pix_sop = 1'b0; sif.pix_data = 24'h123456;
      err_clr = 1'b1;
      #1 chk("origin_nosop_ready", 32'(sif.pix_ready), 32'd0);
      tick();
      err_clr = 1'b0;
      chk("origin_nosop_se", 32'(sync_err), 32'd1);
      chk("origin_nosop_rgb", 32'(rgb), 32'd0);
      sif.pix_valid = 1'b0;

      // asynchronous reset mid-frame
      go_slot(1584 + 2 * HT + 3);
      tick();
      chk("pre_rst_blank", 32'(blank_n), 32'd1);
      chk("pre_rst_vclk", 32'(vclk), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_blank", 32'(blank_n), 32'd0);
      chk("mid_rst_vclk", 32'(vclk), 32'd0);
      chk("mid_rst_se", 32'(sync_err), 32'd0);
      chk("mid_rst_hs_vs", {30'd0, hs, vs}, 32'd3);
      @(negedge clk);
      reset_n = 1'b1;
      edges   = 0;
      at_edge(1); chk("rel_fs_e1", 32'(frame_start), 32'd0);
      at_edge(2); chk("rel_fs_e2", 32'(frame_start), 32'd1);
                  chk("rel_blank_e2", 32'(blank_n), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
